// File: rtl/arvi_mdu_pkg.sv
// Shared types and constants for the iterative multiply/divide unit:
// FSM states, RV M-extension funct3 encodings, divide special-case results.
package arvi_mdu_pkg;

  localparam int MDU_MAX_XLEN = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } mdu_state_t;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } mdu_f3_t;

  // Quotient for a zero divisor: all ones in the low xlen bits.
  function automatic logic [MDU_MAX_XLEN-1:0] mdu_div0_quotient(input int xlen);
    return {MDU_MAX_XLEN{1'b1}} >> (MDU_MAX_XLEN - xlen);
  endfunction

  // Quotient for signed overflow: the most-negative xlen-bit value.
  function automatic logic [MDU_MAX_XLEN-1:0] mdu_ovf_quotient(input int xlen);
    return {{(MDU_MAX_XLEN-1){1'b0}}, 1'b1} << (xlen - 1);
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One combinational restoring-divide step retiring BPC quotient bits,
// built as a chain of single-bit compare/subtract stages.
module mdu_div_step #(
  parameter int XLEN = 32,
  parameter int BPC  = 1
) (
  input  logic [XLEN-1:0] rem_cur,
  input  logic [XLEN-1:0] quo_cur,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_new,
  output logic [XLEN-1:0] quo_new
);

  logic [XLEN-1:0] rem_c [BPC+1];
  logic [XLEN-1:0] quo_c [BPC+1];

  assign rem_c[0] = rem_cur;
  assign quo_c[0] = quo_cur;

  // quo holds the not-yet-consumed dividend bits at the top and the
  // quotient bits shifting in at the bottom.
  for (genvar gi = 0; gi < BPC; gi++) begin : g_bit
    logic [XLEN:0] trial;
    logic [XLEN:0] diff;
    assign trial = {rem_c[gi], quo_c[gi][XLEN-1]};
    assign diff  = trial - {1'b0, divisor};
    assign rem_c[gi+1] = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
    assign quo_c[gi+1] = {quo_c[gi][XLEN-2:0], ~diff[XLEN]};
  end

  assign rem_new = rem_c[BPC];
  assign quo_new = quo_c[BPC];

endmodule

// File: rtl/ex_mdu.sv
// Execute-stage RV M-extension unit: iterative shift-add multiply and restoring
// divide. Define ARVI_MDU_FAST_MUL_EN for a single-cycle array multiply.
module ex_mdu
  import arvi_mdu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [2:0]      i_f3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_res,
  output logic            o_stall
);

  localparam int BPC    = BITS_PER_CYCLE;
  localparam int STEPS  = XLEN / BPC;
  localparam int STEP_W = $clog2(STEPS);
  localparam logic [XLEN-1:0]   DIV0_Q    = XLEN'(mdu_div0_quotient(XLEN));
  localparam logic [XLEN-1:0]   MOST_NEG  = XLEN'(mdu_ovf_quotient(XLEN));
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  mdu_state_t        state_reg;
  mdu_f3_t           f3_reg;
  logic [STEP_W-1:0] cnt_reg;
  logic [XLEN-1:0]   a_reg;
  logic [XLEN-1:0]   b_reg;
  logic [XLEN-1:0]   rem_reg;
  logic [XLEN-1:0]   quo_reg;
  logic [2*XLEN-1:0] prod_reg;
  logic              neg_reg;
  logic              neg_rem_reg;
  logic [XLEN-1:0]   res_reg;
  logic              valid_reg;

  // Request decode: operand signedness, magnitudes and divide special cases.
  logic            rs1_signed, rs2_signed, rs1_neg, rs2_neg;
  logic [XLEN-1:0] rs1_mag, rs2_mag, special_res;
  logic            div_zero, div_ovf;

  always_comb begin
    rs1_signed  = i_f3[2] ? !i_f3[0] : (i_f3[1:0] != 2'b11);
    rs2_signed  = i_f3[2] ? !i_f3[0] : !i_f3[1];
    rs1_neg     = rs1_signed && i_rs1[XLEN-1];
    rs2_neg     = rs2_signed && i_rs2[XLEN-1];
    rs1_mag     = rs1_neg ? -i_rs1 : i_rs1;
    rs2_mag     = rs2_neg ? -i_rs2 : i_rs2;
    div_zero    = (i_rs2 == '0);
    div_ovf     = !i_f3[0] && (i_rs1 == MOST_NEG) && (i_rs2 == '1);
    special_res = div_zero ? (i_f3[1] ? i_rs1 : DIV0_Q)
                           : (i_f3[1] ? '0 : MOST_NEG);
  end

  // Shift-add step: add a * (low BPC multiplier bits) into the upper half,
  // then shift the whole accumulator right by BPC.
  logic [BPC-1:0]      mul_chunk;
  logic [XLEN+BPC-1:0] mul_partial, mul_sum;
  logic [2*XLEN-1:0]   prod_step;

  assign mul_chunk   = prod_reg[BPC-1:0];
  assign mul_partial = (XLEN+BPC)'(a_reg) * (XLEN+BPC)'(mul_chunk);
  assign mul_sum     = (XLEN+BPC)'(prod_reg[2*XLEN-1:XLEN]) + mul_partial;
  assign prod_step   = {mul_sum, prod_reg[XLEN-1:BPC]};

  logic [XLEN-1:0] rem_step, quo_step;

  mdu_div_step #(
    .XLEN (XLEN),
    .BPC  (BPC)
  ) u_div_step (
    .rem_cur (rem_reg),
    .quo_cur (quo_reg),
    .divisor (b_reg),
    .rem_new (rem_step),
    .quo_new (quo_step)
  );

  logic [2*XLEN-1:0] mul_mag, mul_signed;
  logic              mul_neg, mul_low;
  logic [XLEN-1:0]   mul_res;

`ifdef ARVI_MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_mag;
  assign fast_mag = (2*XLEN)'(rs1_mag) * (2*XLEN)'(rs2_mag);
  // In IDLE the result comes straight from the request; otherwise from the iteration.
  assign mul_mag  = (state_reg == ST_IDLE) ? fast_mag : prod_step;
  assign mul_neg  = (state_reg == ST_IDLE) ? (rs1_neg ^ rs2_neg) : neg_reg;
  assign mul_low  = (state_reg == ST_IDLE) ? (mdu_f3_t'(i_f3) == F3_MUL)
                                           : (f3_reg == F3_MUL);
`else
  assign mul_mag  = prod_step;
  assign mul_neg  = neg_reg;
  assign mul_low  = (f3_reg == F3_MUL);
`endif

  assign mul_signed = mul_neg ? -mul_mag : mul_mag;
  assign mul_res    = mul_low ? mul_signed[XLEN-1:0] : mul_signed[2*XLEN-1:XLEN];

  logic [XLEN-1:0] quo_signed, rem_signed, div_res;

  assign quo_signed = neg_reg ? -quo_step : quo_step;
  assign rem_signed = neg_rem_reg ? -rem_step : rem_step;
  assign div_res    = f3_reg[1] ? rem_signed : quo_signed;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      valid_reg <= 1'b0;
      res_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (i_valid) begin
            f3_reg      <= mdu_f3_t'(i_f3);
            a_reg       <= rs1_mag;
            b_reg       <= rs2_mag;
            neg_reg     <= rs1_neg ^ rs2_neg;
            neg_rem_reg <= rs1_neg;
            prod_reg    <= {{XLEN{1'b0}}, rs2_mag};
            rem_reg     <= '0;
            quo_reg     <= rs1_mag;
            cnt_reg     <= '0;
            if (i_f3[2]) begin
              if (div_zero || div_ovf) begin
                res_reg   <= special_res;
                valid_reg <= 1'b1;
                state_reg <= ST_DONE;
              end else begin
                state_reg <= ST_DIV;
              end
            end else begin
`ifdef ARVI_MDU_FAST_MUL_EN
              res_reg   <= mul_res;
              valid_reg <= 1'b1;
              state_reg <= ST_DONE;
`else
              state_reg <= ST_MUL;
`endif
            end
          end
        end
        ST_MUL: begin
          prod_reg <= prod_step;
          cnt_reg  <= cnt_reg + STEP_W'(1);
          if (cnt_reg == LAST_STEP) begin
            res_reg   <= mul_res;
            valid_reg <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DIV: begin
          rem_reg <= rem_step;
          quo_reg <= quo_step;
          cnt_reg <= cnt_reg + STEP_W'(1);
          if (cnt_reg == LAST_STEP) begin
            res_reg   <= div_res;
            valid_reg <= 1'b1;
            state_reg <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            res_reg   <= '0;
            valid_reg <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign o_ready = (state_reg == ST_IDLE);
  assign o_valid = valid_reg;
  assign o_res   = res_reg;
  assign o_stall = (i_valid && state_reg == ST_IDLE) || (state_reg == ST_MUL)
                || (state_reg == ST_DIV) || (state_reg == ST_DONE && !i_ready);

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: XLEN=32/BPC=1 main instance plus an XLEN=64/BPC=4 latency instance.
module tb_ex_mdu;

  localparam int LAT32 = 33;
  localparam int LAT64 = 17;

  logic        clk;
  logic        i_rst, i_valid, i_flush, i_ready;
  logic [2:0]  i_f3;
  logic [31:0] i_rs1, i_rs2;
  logic        o_ready, o_valid, o_stall;
  logic [31:0] o_res;

  logic        v64, rdy64, flush64;
  logic [2:0]  f3_64;
  logic [63:0] a64, b64;
  logic        ordy64, oval64, ostall64;
  logic [63:0] ores64;

  int checks   = 0;
  int failures = 0;

  ex_mdu #(.XLEN(32), .BITS_PER_CYCLE(1)) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_f3    (i_f3),
    .i_rs1   (i_rs1),
    .i_rs2   (i_rs2),
    .i_flush (i_flush),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_res   (o_res),
    .o_stall (o_stall)
  );

  ex_mdu #(.XLEN(64), .BITS_PER_CYCLE(4)) dut64 (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_valid (v64),
    .o_ready (ordy64),
    .i_f3    (f3_64),
    .i_rs1   (a64),
    .i_rs2   (b64),
    .i_flush (flush64),
    .o_valid (oval64),
    .i_ready (rdy64),
    .o_res   (ores64),
    .o_stall (ostall64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait (bounded) for o_valid, check latency/result/stall,
  // and optionally take the result.
  task automatic run32(input string tag, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res,
                       input int exp_lat, input bit collect);
    int lat;
    bit stall_ok;
    i_f3    = f3;
    i_rs1   = a;
    i_rs2   = b;
    i_valid = 1'b1;
    tick;
    i_valid  = 1'b0;
    lat      = 1;
    stall_ok = 1'b1;
    while (!o_valid && lat < 100) begin
      if (!o_stall) stall_ok = 1'b0;
      tick;
      lat++;
    end
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, 64'(o_res), 64'(exp_res));
    check({tag, "_stall"}, 64'(stall_ok), 64'd1);
    $display("txn %s f3=%0d rs1=0x%08h rs2=0x%08h res=0x%08h lat=%0d", tag, f3, a, b, o_res, lat);
    if (collect) begin
      i_ready = 1'b1;
      tick;
      i_ready = 1'b0;
      check({tag, "_idle"}, 64'(o_ready), 64'd1);
    end
  endtask

  initial begin
    bit seen;
    int lat;
    i_rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b0;
    i_f3 = 3'd0; i_rs1 = '0; i_rs2 = '0;
    v64 = 1'b0; rdy64 = 1'b0; flush64 = 1'b0; f3_64 = 3'd0; a64 = '0; b64 = '0;
    tick;
    tick;
    i_rst = 1'b0;
    #1;
    check("rst_ready", 64'(o_ready), 64'd1);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_res",   64'(o_res),   64'd0);
    check("rst_stall", 64'(o_stall), 64'd0);
    $display("txn reset ready=%0b valid=%0b res=0x%08h stall=%0b", o_ready, o_valid, o_res, o_stall);

    // MUL 7 x -3, then hold the result for 5 cycles before taking it.
    run32("mul_7_m3", 3'd0, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, LAT32, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick;
      check("hold_valid", 64'(o_valid), 64'd1);
      check("hold_res",   64'(o_res),   64'hFFFFFFEB);
      check("hold_stall", 64'(o_stall), 64'd1);
    end
    i_ready = 1'b1;
    #1;
    check("hs_stall", 64'(o_stall), 64'd0);
    tick;
    i_ready = 1'b0;
    check("hs_ready", 64'(o_ready), 64'd1);
    check("hs_valid", 64'(o_valid), 64'd0);
    check("hs_res",   64'(o_res),   64'd0);
    $display("txn handshake ready=%0b valid=%0b", o_ready, o_valid);

    run32("mulhu_max",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, LAT32, 1'b1);
    run32("mulh_m1",    3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, LAT32, 1'b1);
    run32("mulhsu_m1",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, LAT32, 1'b1);
    run32("div_m7_2",   3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, LAT32, 1'b1);
    run32("rem_m7_2",   3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, LAT32, 1'b1);
    run32("rem_7_m2",   3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        LAT32, 1'b1);
    run32("divu_big",   3'd5, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, LAT32, 1'b1);
    run32("divu_zero",  3'd5, 32'h80000000, 32'd0,        32'hFFFFFFFF, 1,     1'b1);
    run32("div_zero",   3'd4, 32'd5,        32'd0,        32'hFFFFFFFF, 1,     1'b1);
    run32("remu_zero",  3'd7, 32'h00001234, 32'd0,        32'h00001234, 1,     1'b1);
    run32("rem_ovf",    3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,     1'b1);
    run32("div_ovf",    3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,     1'b1);

    // Flush a DIV at step 10.
    i_f3 = 3'd4; i_rs1 = 32'd1000; i_rs2 = 32'd3; i_valid = 1'b1;
    tick;
    i_valid = 1'b0;
    repeat (10) tick;
    i_flush = 1'b1;
    tick;
    i_flush = 1'b0;
    check("flush_ready", 64'(o_ready), 64'd1);
    check("flush_valid", 64'(o_valid), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (o_valid) seen = 1'b1;
      tick;
    end
    check("flush_no_valid", 64'(seen), 64'd0);
    $display("txn flush ready=%0b valid_seen=%0b", o_ready, seen);
    run32("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, LAT32, 1'b1);

    // Reset mid-MUL with i_valid held high.
    i_f3 = 3'd0; i_rs1 = 32'd5; i_rs2 = 32'd6; i_valid = 1'b1;
    tick;
    repeat (5) tick;
    i_rst = 1'b1;
    tick;
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_res",   64'(o_res),   64'd0);
    check("midrst_ready", 64'(o_ready), 64'd1);
    i_rst = 1'b0;
    i_valid = 1'b0;
    #1;
    check("midrst_stall", 64'(o_stall), 64'd0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (o_valid) seen = 1'b1;
      tick;
    end
    check("midrst_no_valid", 64'(seen), 64'd0);
    $display("txn midreset ready=%0b valid_seen=%0b", o_ready, seen);

    // XLEN=64, BPC=4 rerun of MUL 7 x -3.
    f3_64 = 3'd0; a64 = 64'd7; b64 = 64'hFFFFFFFFFFFFFFFD; v64 = 1'b1;
    tick;
    v64 = 1'b0;
    lat = 1;
    while (!oval64 && lat < 100) begin
      tick;
      lat++;
    end
    check("mul64_lat", 64'(lat), 64'(LAT64));
    check("mul64_res", ores64, 64'hFFFFFFFFFFFFFFEB);
    $display("txn mul64 res=0x%016h lat=%0d", ores64, lat);
    rdy64 = 1'b1;
    tick;
    rdy64 = 1'b0;
    check("mul64_idle", 64'(ordy64), 64'd1);
    check("mul64_stall", 64'(ostall64), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mdu.md
EX_MDU -- requirements
Module: ex_mdu

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; legal values 32 and 64.
REQ-002 Parameter BITS_PER_CYCLE, default 1, iterative bits retired per cycle; legal values 1, 2, 4; SHALL divide XLEN.
REQ-003 i_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  in  1  synchronous, active-high reset.
REQ-005 i_valid  in  1  request present; operands and i_f3 stable while i_valid && !o_ready.
REQ-006 o_ready  out  1  unit accepts a request this cycle.
REQ-007 i_f3  in  3  RV M-extension funct3 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU = 0..7).
REQ-008 i_rs1, i_rs2  in  XLEN  operands.
REQ-009 i_flush  in  1  abort in-flight operation.
REQ-010 o_valid  out  1  o_res holds a completed result.
REQ-011 i_ready  in  1  consumer takes the result this cycle.
REQ-012 o_res  out  XLEN  result.
REQ-013 o_stall  out  1  pipeline stall request to hazard unit.

Function
REQ-014 FSM states IDLE, MUL, DIV, DONE; o_ready SHALL be 1 only in IDLE.
REQ-015 Accept on i_valid && o_ready: latch operands (sign-corrected magnitudes), f3, and result-sign flags; go to MUL (f3[2]=0) or DIV (f3[2]=1).
REQ-016 MUL/DIV SHALL iterate XLEN/BITS_PER_CYCLE cycles via a step counter, then enter DONE; accept-to-o_valid latency = XLEN/BITS_PER_CYCLE + 1 cycles.
REQ-017 Multiply product 2*XLEN wide; MUL returns low XLEN bits, MULH/MULHSU/MULHU high XLEN bits with signed x signed, signed x unsigned, unsigned x unsigned interpretation.
REQ-018 Divide: restoring, quotient rounds toward zero, remainder sign = dividend sign.
REQ-019 Divide by zero: skip DIV, enter DONE next cycle; quotient = all ones, remainder = i_rs1.
REQ-020 Signed overflow (DIV/REM, rs1 = most-negative, rs2 = -1): skip DIV, enter DONE next cycle; quotient = most-negative, remainder = 0.
REQ-021 DONE: o_valid = 1, o_res held stable until i_valid... i.e. until i_ready; on i_ready go IDLE.
REQ-022 No new request is accepted in the same cycle as a DONE handshake (one bubble cycle in IDLE minimum).
REQ-023 o_stall = (i_valid && state == IDLE) || state in {MUL, DIV} || (state == DONE && !i_ready).
REQ-024 i_flush in any state: next state IDLE, o_valid low next cycle, result discarded; i_flush has priority over i_ready and acceptance.
REQ-025 o_res SHALL be 0 whenever o_valid = 0.

Reset
REQ-026 i_rst SHALL force state IDLE, step counter 0, o_valid 0, o_res 0, o_ready 1 (after the reset edge), o_stall 0 absent i_valid.
REQ-027 i_rst mid-operation SHALL abort identically to i_flush, overriding all other inputs.

Configuration
REQ-028 Macro ARVI_MDU_FAST_MUL_EN: when defined, multiplies SHALL bypass MUL using a single-cycle array multiply, entering DONE the cycle after acceptance (latency 1).
REQ-029 Without ARVI_MDU_FAST_MUL_EN, multiplies SHALL use the iterative shift-add path of REQ-016; divide behaviour is identical either way.

Structure
REQ-030 Shared package arvi_mdu_pkg SHALL hold the FSM state enum, the funct3 encoding enum, and the divide-by-zero/overflow constant functions parametrised by XLEN.
REQ-031 One sub-module mdu_div_step SHALL implement one BITS_PER_CYCLE-wide restoring divide step (combinational), instantiated in ex_mdu.
REQ-032 ex_mdu SHALL replace the previous M-unit interface inside the execute stage; o_stall feeds the existing stall network.

Verification
REQ-033 XLEN=32, BPC=1, MUL 7 x -3 -> o_valid after 33 cycles, o_res = 0xFFFFFFEB; o_stall high the whole wait.
REQ-034 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> o_res = 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-035 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 0x80000000 / 0 -> 0xFFFFFFFF after 1 cycle; REM 0x80000000 % 0xFFFFFFFF -> 0.
REQ-036 Result held with i_ready = 0 for 5 cycles -> o_res/o_valid stable, o_stall high; i_ready = 1 -> IDLE next cycle, o_ready = 1.
REQ-037 i_flush at step 10 of a DIV -> o_valid never asserts, IDLE next cycle; new DIVU 100 / 7 then returns 14.
REQ-038 i_rst asserted mid-MUL with i_valid high -> all outputs at reset values next cycle; BPC=4 and XLEN=64 rerun of REQ-033 gives latency 17.
